// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared packet types, field offsets and parity helper for the router
package router_pkg;

   typedef enum logic [1:0] {
      UNICAST = 2'b00,
      BCAST   = 2'b01,
      NULL    = 2'b10,
      RSVD    = 2'b11
   } pkt_type_e;

   // Packet layout, LSB first: dest, type (2 bits), payload, parity.
   function automatic int type_lsb(input int addr_w);
      return addr_w;
   endfunction

   function automatic int payload_lsb(input int addr_w);
      return addr_w + 2;
   endfunction

   function automatic int parity_pos(input int addr_w, input int data_w);
      return addr_w + 2 + data_w;
   endfunction

   function automatic int pkt_width(input int addr_w, input int data_w);
      return parity_pos(addr_w, data_w) + 1;
   endfunction

   // Even-parity bit for the given field: makes the total count of ones even.
   function automatic logic calc_parity(input logic [63:0] bits);
      return ^bits;
   endfunction

endpackage

// File: rtl/pkt_router_nport_if.sv
// rtl/pkt_router_nport_if.sv - packet input and per-port output bundle of the router
interface pkt_router_nport_if #(
   parameter int NPORT  = 4,
   parameter int DATA_W = 8
);
   import router_pkg::*;

   localparam int ADDR_W = $clog2(NPORT);
   localparam int PKT_W  = pkt_width(ADDR_W, DATA_W);

   logic [PKT_W-1:0]        in_packet;
   logic                    in_valid;
   logic                    in_ready;
   logic [NPORT-1:0]        out_valid;
   logic [NPORT-1:0]        out_ready;
   logic [NPORT*DATA_W-1:0] out_data;
   logic [15:0]             drop_cnt;
   logic [15:0]             pkt_cnt;

   modport master (
      output in_packet, in_valid, out_ready,
      input  in_ready, out_valid, out_data, drop_cnt, pkt_cnt
   );

   modport slave (
      input  in_packet, in_valid, out_ready,
      output in_ready, out_valid, out_data, drop_cnt, pkt_cnt
   );

endinterface

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - single-clock output FIFO with wrap-bit pointers
module router_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] data_in,
   output logic              full,
   input  logic              pop,
   output logic [DATA_W-1:0] data_out,
   output logic              empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              do_push, do_pop;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign data_out = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer advance; push and pop in the same cycle both take effect.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   // Pointer registers; reset empties the FIFO at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents are meaningless while empty so it carries no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_in;
   end

endmodule

// File: rtl/pkt_router_nport.sv
// rtl/pkt_router_nport.sv - parity-checked unicast/broadcast router into per-port FIFOs
module pkt_router_nport
   import router_pkg::*;
#(
   parameter int NPORT  = 4,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   pkt_router_nport_if.slave bus
);
   localparam int          ADDR_W   = $clog2(NPORT);
   localparam int          TYPE_LSB = type_lsb(ADDR_W);
   localparam int          PAY_LSB  = payload_lsb(ADDR_W);
   localparam int          PAR_POS  = parity_pos(ADDR_W, DATA_W);
   localparam logic [15:0] CNT_MAX  = 16'hFFFF;

   logic [ADDR_W-1:0]       dest;
   pkt_type_e               ptype;
   logic [DATA_W-1:0]       payload;
   logic                    par_ok;
   logic [NPORT-1:0]        full, empty, push_vec, pop_vec;
   logic [NPORT*DATA_W-1:0] out_data;
   logic                    in_ready, count_pkt, count_drop;
   logic [15:0]             pkt_cnt_q, pkt_cnt_d;
   logic [15:0]             drop_cnt_q, drop_cnt_d;

   assign dest    = bus.in_packet[ADDR_W-1:0];
   assign ptype   = pkt_type_e'(bus.in_packet[TYPE_LSB +: 2]);
   assign payload = bus.in_packet[PAY_LSB +: DATA_W];
   assign par_ok  = (bus.in_packet[PAR_POS] == calc_parity(64'(bus.in_packet[PAR_POS-1:0])));

   // Decode: ready depends only on the packet and the full flags, never on out_ready.
   // A bad parity bit overrides whatever the type field says.
   always_comb begin
      in_ready   = 1'b1;
      push_vec   = '0;
      count_pkt  = 1'b0;
      count_drop = 1'b0;
      if (!par_ok) begin
         count_drop = bus.in_valid;
      end else begin
         case (ptype)
            UNICAST: begin
               in_ready = !full[dest];
               if (bus.in_valid && !full[dest]) begin
                  push_vec[dest] = 1'b1;
                  count_pkt      = 1'b1;
               end
            end
            BCAST: begin
               // All-or-nothing: one full port holds the whole broadcast back.
               in_ready = ~|full;
               if (bus.in_valid && ~|full) begin
                  push_vec  = '1;
                  count_pkt = 1'b1;
               end
            end
            RSVD:    count_drop = bus.in_valid;
            default: ;
         endcase
      end
   end

   // Saturating statistics counters.
   always_comb begin
      pkt_cnt_d  = pkt_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (count_pkt && pkt_cnt_q != CNT_MAX)   pkt_cnt_d  = pkt_cnt_q + 16'd1;
      if (count_drop && drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + 16'd1;
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pkt_cnt_q  <= '0;
         drop_cnt_q <= '0;
      end else begin
         pkt_cnt_q  <= pkt_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   for (genvar p = 0; p < NPORT; p++) begin : g_port
      assign pop_vec[p] = !empty[p] && bus.out_ready[p];

      router_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk      (clk),
         .rst      (rst),
         .push     (push_vec[p]),
         .data_in  (payload),
         .full     (full[p]),
         .pop      (pop_vec[p]),
         .data_out (out_data[p*DATA_W +: DATA_W]),
         .empty    (empty[p])
      );
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = ~empty;
   assign bus.out_data  = out_data;
   assign bus.pkt_cnt   = pkt_cnt_q;
   assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_pkt_router_nport.sv
// tb/tb_pkt_router_nport.sv - scoreboard bench for pkt_router_nport
module tb_pkt_router_nport;
   localparam int NPORT  = 4;
   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int PKT_W  = 13;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pkt_router_nport_if #(.NPORT(NPORT), .DATA_W(DATA_W)) bus();

   pkt_router_nport #(.NPORT(NPORT), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   logic [DATA_W-1:0] sb [NPORT][$];
   logic [NPORT-1:0]  pend_mask = '0;
   logic [DATA_W-1:0] pend_data = '0;
   bit                pend_pkt  = 0;
   bit                pend_drop = 0;
   int                exp_pkt   = 0;
   int                exp_drop  = 0;
   bit                acc;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [PKT_W-1:0] mk(input int dest, input int typ, input int payload, input bit bad);
      int lower;
      logic [PKT_W-1:0] p;
      lower = dest + typ * NPORT + payload * NPORT * 4;
      p = PKT_W'(lower);
      if ((($countones(lower) % 2) == 1) != bad) p[PKT_W-1] = 1'b1;
      return p;
   endfunction

   // Reference behaviour from the packet rules and the current queue occupancies.
   task automatic model(input logic [PKT_W-1:0] pkt, output bit rdy, output logic [NPORT-1:0] mask,
                        output logic [DATA_W-1:0] data, output bit cnt, output bit drop);
      int v;
      int dest;
      int typ;
      v    = int'(pkt);
      dest = v % NPORT;
      typ  = (v / NPORT) % 4;
      data = DATA_W'((v / (NPORT * 4)) % 256);
      rdy  = 1; mask = '0; cnt = 0; drop = 0;
      if (($countones(pkt) % 2) != 0) begin
         drop = 1;
      end else if (typ == 0) begin
         rdy = (sb[dest].size() < DEPTH);
         mask[dest] = 1'b1;
         cnt = 1;
      end else if (typ == 1) begin
         for (int p = 0; p < NPORT; p++) if (sb[p].size() >= DEPTH) rdy = 0;
         mask = '1;
         cnt = 1;
      end else if (typ == 3) begin
         drop = 1;
      end
   endtask

   task automatic drive(input logic [PKT_W-1:0] pkt, input bit v, input logic [NPORT-1:0] rdy_o, output bit accepted);
      bit rdy, cnt, drop;
      logic [NPORT-1:0]  mask;
      logic [DATA_W-1:0] data;
      @(negedge clk);
      #1;
      bus.in_packet = pkt;
      bus.in_valid  = v;
      bus.out_ready = rdy_o;
      #1;
      model(pkt, rdy, mask, data, cnt, drop);
      check("in_ready", bus.in_ready, rdy);
      accepted = v && rdy;
      if (accepted) begin
         pend_mask = mask;
         pend_data = data;
         pend_pkt  = cnt;
         pend_drop = drop;
      end
   endtask

   task automatic send(input logic [PKT_W-1:0] pkt, input logic [NPORT-1:0] rdy_o, input int tries);
      bit a;
      a = 0;
      for (int i = 0; i < tries && !a; i++) drive(pkt, 1'b1, rdy_o, a);
      if (!a) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: packet %0h not accepted within %0d cycles", pkt, tries);
      end
   endtask

   task automatic idle(input logic [NPORT-1:0] rdy_o, input int n);
      bit a;
      for (int i = 0; i < n; i++) drive('0, 1'b0, rdy_o, a);
   endtask

   // Monitor: compares outputs shortly before each rising edge, pops on handshakes,
   // then commits the write the driver issued for that edge.
   always @(negedge clk) begin
      #4;
      for (int p = 0; p < NPORT; p++) begin
         check($sformatf("out_valid[%0d]", p), bus.out_valid[p], sb[p].size() > 0);
         if (sb[p].size() > 0) begin
            check($sformatf("out_data[%0d]", p), bus.out_data[p*DATA_W +: DATA_W], sb[p][0]);
            if (bus.out_ready[p]) void'(sb[p].pop_front());
         end
      end
      check("pkt_cnt", bus.pkt_cnt, exp_pkt);
      check("drop_cnt", bus.drop_cnt, exp_drop);
      for (int p = 0; p < NPORT; p++) if (pend_mask[p]) sb[p].push_back(pend_data);
      if (pend_pkt && exp_pkt < 65535) exp_pkt++;
      if (pend_drop && exp_drop < 65535) exp_drop++;
      pend_mask = '0;
      pend_pkt  = 0;
      pend_drop = 0;
   end

   task automatic release_rst();
      @(negedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_pkt_cnt", bus.pkt_cnt, 0);
      check("rst_drop_cnt", bus.drop_cnt, 0);
      rst = 1'b1;
   endtask

   initial begin
      bus.in_packet = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = '0;

      // Under reset every packet type sees in_ready=1.
      for (int t = 0; t < 4; t++) drive(mk(1, t, 8'h5A, 0), 1'b0, 4'hF, acc);
      drive(mk(2, 0, 8'h5A, 1), 1'b0, 4'hF, acc);
      release_rst();

      // Single unicast, one-cycle latency.
      send(mk(2, 0, 8'hAA, 0), 4'hF, 1);
      drive('0, 1'b0, 4'hF, acc);
      check("t033_out_valid", bus.out_valid, 4'b0100);
      check("t033_out_data", bus.out_data[2*DATA_W +: DATA_W], 8'hAA);
      check("t033_pkt_cnt", bus.pkt_cnt, 1);
      idle(4'hF, 2);

      // Port 1 stalled: fill, block, pop-in-same-cycle still blocks, then accept.
      for (int i = 1; i <= 4; i++) send(mk(1, 0, i, 0), 4'b1101, 1);
      drive(mk(1, 0, 5, 0), 1'b1, 4'b1101, acc);
      check("t034_full_block", bus.in_ready, 0);
      drive(mk(1, 0, 5, 0), 1'b1, 4'hF, acc);
      check("t034_pop_no_bypass", bus.in_ready, 0);
      send(mk(1, 0, 5, 0), 4'hF, 3);
      idle(4'hF, 6);

      // Broadcast blocked by a full port 3, then released.
      for (int i = 0; i < 4; i++) send(mk(3, 0, 8'h30 + i, 0), 4'b0111, 1);
      drive(mk(0, 1, 8'hCC, 0), 1'b1, 4'b0111, acc);
      check("t035_bcast_block", bus.in_ready, 0);
      drive(mk(0, 1, 8'hCC, 0), 1'b1, 4'b1111, acc);
      check("t035_bcast_pop_block", bus.in_ready, 0);
      send(mk(0, 1, 8'hCC, 0), 4'b0111, 2);
      drive('0, 1'b0, 4'b0111, acc);
      check("t035_all_valid", bus.out_valid, 4'hF);
      check("t035_port0_cc", bus.out_data[0 +: DATA_W], 8'hCC);
      idle(4'hF, 6);

      // Parity error and reserved type are dropped.
      send(mk(0, 0, 8'hBB, 1), 4'hF, 1);
      send(mk(1, 3, 8'h11, 0), 4'hF, 1);
      send(mk(2, 2, 8'h22, 0), 4'hF, 1);
      drive('0, 1'b0, 4'hF, acc);
      check("t036_drop_cnt", bus.drop_cnt, 2);
      check("t036_no_valid", bus.out_valid, 0);

      // Full port 0 with a pop in the same cycle refuses the push.
      for (int i = 1; i <= 4; i++) send(mk(0, 0, 8'h40 + i, 0), 4'b0000, 1);
      drive(mk(0, 0, 8'h4F, 0), 1'b1, 4'b0001, acc);
      check("t037_full_push", bus.in_ready, 0);
      drive('0, 1'b0, 4'b0000, acc);
      check("t037_head_after_pop", bus.out_data[0 +: DATA_W], 8'h42);
      idle(4'hF, 5);

      // Reset mid-operation discards FIFO contents and counters.
      for (int i = 0; i < 2; i++) begin
         send(mk(0, 0, 8'h50 + i, 0), 4'b0000, 1);
         send(mk(1, 0, 8'h60 + i, 0), 4'b0000, 1);
      end
      @(negedge clk);
      #2;
      bus.in_valid = 1'b0;
      rst = 1'b0;
      #1;
      check("t038_valid_cleared", bus.out_valid, 0);
      check("t038_pkt_cleared", bus.pkt_cnt, 0);
      check("t038_drop_cleared", bus.drop_cnt, 0);
      for (int p = 0; p < NPORT; p++) sb[p].delete();
      exp_pkt = 0;
      exp_drop = 0;
      pend_mask = '0;
      pend_pkt = 0;
      pend_drop = 0;
      idle(4'h0, 2);
      release_rst();
      for (int i = 0; i < 4; i++) send(mk(0, 0, 8'h70 + i, 0), 4'b0000, 1);
      idle(4'hF, 6);

      // Randomized traffic against the reference model.
      for (int n = 0; n < 500; n++) begin
         drive(mk($urandom_range(0, NPORT - 1), $urandom_range(0, 3), $urandom_range(0, 255),
                  $urandom_range(0, 7) == 0),
               $urandom_range(0, 3) != 0, NPORT'($urandom), acc);
      end
      idle(4'hF, DEPTH + 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pkt_router_nport.md
PKT_ROUTER_NPORT -- requirements
Module: pkt_router_nport

Interface
REQ-001 Parameter NPORT, default 4, number of output ports; SHALL be 2..8 and a power of 2.
REQ-002 Parameter DATA_W, default 8, payload width in bits.
REQ-003 Parameter DEPTH, default 4, entries per output FIFO; SHALL be a power of 2, minimum 2.
REQ-004 Derived constants: ADDR_W = log2(NPORT); PKT_W = ADDR_W+2+DATA_W+1 (13 at defaults).
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-low; release is synchronous to clk.
REQ-007 in_packet  input  PKT_W  packet: [ADDR_W-1:0] dest, [ADDR_W+1:ADDR_W] type, next DATA_W bits payload, MSB even parity over all lower bits.
REQ-008 in_valid  input  1  in_packet is valid.
REQ-009 in_ready  output  1  router accepts in_packet this cycle.
REQ-010 out_valid  output  NPORT  per-port head entry valid.
REQ-011 out_ready  input  NPORT  per-port consumer accepts the head entry.
REQ-012 out_data  output  NPORT*DATA_W  per-port head payload; port p occupies bits [p*DATA_W +: DATA_W].
REQ-013 drop_cnt  output  16  count of dropped packets.
REQ-014 pkt_cnt  output  16  count of packets written to at least one FIFO.

Function
REQ-015 Accept occurs on a rising edge with in_valid=1 and in_ready=1; the payload of an accepted packet SHALL be written at that edge, with no other input-side state.
REQ-016 Type 2'b00 (UNICAST): write payload to FIFO[dest]; in_ready = !full[dest].
REQ-017 Type 2'b01 (BCAST): write payload to all NPORT FIFOs in the same edge; in_ready = no FIFO full; no partial broadcast SHALL occur.
REQ-018 Type 2'b10 (NULL): in_ready=1; packet consumed, no write, no counter change.
REQ-019 Type 2'b11 (RSVD), or parity mismatch of any type: in_ready=1; packet consumed, no write, drop_cnt increments.
REQ-020 Parity check SHALL take precedence over type decode.
REQ-021 in_ready SHALL be combinational from FIFO full flags and in_packet only, never from out_ready; a full FIFO SHALL block even if popped in the same cycle.
REQ-022 Latency: payload accepted at edge k SHALL appear on out_valid/out_data of an empty target port after edge k, i.e. one cycle.
REQ-023 Pop occurs on port p when out_valid[p]=1 and out_ready[p]=1; out_data[p] SHALL hold stable while out_valid[p]=1 and out_ready[p]=0.
REQ-024 Simultaneous push and pop on a non-full FIFO SHALL both take effect; occupancy is unchanged.
REQ-025 FIFO pointers SHALL use ADDR bits plus one wrap bit; full = MSBs differ and lower bits equal; empty = pointers equal; wrap-around is transparent.
REQ-026 Ordering within each port SHALL be FIFO; ports are independent.
REQ-027 drop_cnt and pkt_cnt SHALL saturate at 16'hFFFF.
REQ-028 out_valid SHALL NOT depend combinationally on in_valid.

Reset
REQ-029 While rst=0: all pointers are 0, out_valid=0, drop_cnt=0, pkt_cnt=0, and in_ready = 1 for every packet type.
REQ-030 Reset mid-operation SHALL discard all FIFO contents immediately; FIFO storage needs no reset and out_data is don't-care while out_valid=0.

Structure
REQ-031 Package router_pkg SHALL hold the pkt_type_e enum (UNICAST, BCAST, NULL, RSVD), field-offset functions of ADDR_W/DATA_W, and the parity function.
REQ-032 Sub-module router_fifo (parameters DATA_W, DEPTH; ports push, data_in, full, pop, data_out, empty) SHALL be instantiated NPORT times by generate.

Verification
REQ-033 Defaults; unicast dest=2, payload 8'hAA, correct parity, all out_ready=1 -> out_valid=4'b0100 one cycle later, out_data[2]=8'hAA, pkt_cnt=1.
REQ-034 Hold out_ready[1]=0; send 5 unicasts to port 1, payloads 8'h01..8'h05 -> first 4 accepted, in_ready=0 on the 5th; release out_ready -> 01,02,03,04 in order, then 05 accepted.
REQ-035 Broadcast 8'hCC with port 3 full -> in_ready=0, no FIFO written; drain one entry from port 3 -> broadcast accepted, 8'hCC appears on all 4 ports.
REQ-036 Unicast 8'hBB to port 0 with parity bit inverted, then a type-2'b11 packet -> both consumed, no out_valid, drop_cnt=2, pkt_cnt unchanged.
REQ-037 Port 0 full; same-cycle pop and push attempt -> push refused, pop completes, occupancy drops to 3.
REQ-038 Fill ports 0 and 1 with 2 entries each, assert rst=0 between clock edges -> out_valid=0 and counters 0 immediately; after release, port 0 accepts 4 new entries.
